// File: rtl/spi_slave.sv
// SPI slave front end: 10-bit command frames in on MOSI, 8-bit memory read data out on MISO.
// Optional input synchroniser on SS_n/MOSI enabled by defining SPI_SYNC_IN_EN.
module spi_slave #(
    parameter int TX_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                SS_n,
    input  logic                MOSI,
    output logic                MISO,
    output logic [TX_WIDTH+1:0] rx_data,
    output logic                rx_valid,
    input  logic [TX_WIDTH-1:0] tx_data,
    input  logic                tx_valid
);

    localparam int CW = TX_WIDTH + 2;
    localparam int BW = $clog2(CW + 1);
    localparam int TW = $clog2(TX_WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_t;

    state_t state;
    state_t state_nxt;

    logic ss;
    logic mosi;

`ifdef SPI_SYNC_IN_EN
    logic [1:0] ss_q;
    logic [1:0] mosi_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ss_q   <= 2'b11;
            mosi_q <= 2'b00;
        end else begin
            ss_q   <= {ss_q[0], SS_n};
            mosi_q <= {mosi_q[0], MOSI};
        end
    end

    assign ss   = ss_q[1];
    assign mosi = mosi_q[1];
`else
    assign ss   = SS_n;
    assign mosi = MOSI;
`endif

    logic [BW-1:0]       bit_cnt;
    logic [CW-2:0]       rx_sh;
    logic                rd_addr_seen;
    logic                tx_wait;
    logic                tx_busy;
    logic [TW-1:0]       tx_cnt;
    logic [TX_WIDTH-1:0] tx_sh;

    logic in_frame;
    logic rx_take;
    logic rx_done;
    logic tx_cap;

    always_comb begin
        in_frame = (state == WRITE) || (state == READ_ADD) ||
                   (state == READ_DATA);
        rx_take  = !ss && ((state == CHK_CMD) ||
                   (in_frame && (bit_cnt != BW'(CW))));
        rx_done  = rx_take && in_frame && (bit_cnt == BW'(CW - 1));
        tx_cap   = !ss && (state == READ_DATA) && tx_wait && tx_valid;
    end

    // Routing only looks at bit 9 and whether a read address is pending
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (!ss) state_nxt = CHK_CMD;
            end
            CHK_CMD: begin
                if (ss)                state_nxt = IDLE;
                else if (!mosi)        state_nxt = WRITE;
                else if (rd_addr_seen) state_nxt = READ_DATA;
                else                   state_nxt = READ_ADD;
            end
            WRITE, READ_ADD, READ_DATA: begin
                if (ss) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt      <= '0;
            rx_sh        <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rd_addr_seen <= 1'b0;
            tx_wait      <= 1'b0;
            tx_busy      <= 1'b0;
            tx_cnt       <= '0;
            tx_sh        <= '0;
            MISO         <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (ss) begin
                bit_cnt <= '0;
                rx_sh   <= '0;
                tx_wait <= 1'b0;
                tx_busy <= 1'b0;
                tx_cnt  <= '0;
                tx_sh   <= '0;
                MISO    <= 1'b0;
            end else begin
                if (rx_take) begin
                    rx_sh   <= {rx_sh[CW-3:0], mosi};
                    bit_cnt <= bit_cnt + BW'(1);
                end
                if (rx_done) begin
                    rx_valid <= 1'b1;
                    rx_data  <= {rx_sh, mosi};
                    if (state == READ_ADD) rd_addr_seen <= 1'b1;
                    if (state == READ_DATA) begin
                        rd_addr_seen <= 1'b0;
                        tx_wait      <= 1'b1;
                    end
                end
                // MSB goes out straight from tx_data on the capture edge
                if (tx_cap) begin
                    tx_wait <= 1'b0;
                    tx_busy <= 1'b1;
                    MISO    <= tx_data[TX_WIDTH-1];
                    tx_sh   <= {tx_data[TX_WIDTH-2:0], 1'b0};
                    tx_cnt  <= TW'(TX_WIDTH - 1);
                end else if (tx_busy) begin
                    if (tx_cnt != '0) begin
                        MISO   <= tx_sh[TX_WIDTH-1];
                        tx_sh  <= tx_sh << 1;
                        tx_cnt <= tx_cnt - TW'(1);
                    end else begin
                        MISO    <= 1'b0;
                        tx_busy <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: write, read pair, flag routing, abort,
// delayed memory response and mid-frame reset.
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_valid;

    int checks   = 0;
    int failures = 0;

    spi_slave #(.TX_WIDTH(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .SS_n     (SS_n),
        .MOSI     (MOSI),
        .MISO     (MISO),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Full frame; returns just after the edge sampling bit 0
    task automatic frame(input logic [9:0] w, input string tag);
        SS_n = 1'b0;
        tick();
        for (int i = 9; i >= 0; i--) begin
            MOSI = w[i];
            tick();
            if (i > 0) chk({tag, "_rv_lo"}, 32'(rx_valid), 32'd0);
        end
        chk({tag, "_rv"}, 32'(rx_valid), 32'd1);
        chk({tag, "_data"}, 32'(rx_data), 32'(w));
    endtask

    task automatic idle(input int n);
        SS_n = 1'b1;
        MOSI = 1'b0;
        for (int i = 0; i < n; i++) tick();
    endtask

    logic [7:0]  exp_byte;
    logic [9:0]  w;

    initial begin
        rst_n    = 1'b0;
        SS_n     = 1'b1;
        MOSI     = 1'b0;
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        tick();
        tick();
        chk("rst_miso", 32'(MISO), 32'd0);
        chk("rst_rv", 32'(rx_valid), 32'd0);
        chk("rst_data", 32'(rx_data), 32'd0);
        chk("rst_flag", 32'(dut.rd_addr_seen), 32'd0);
        rst_n = 1'b1;
        idle(2);

        // Write address
        frame(10'h0A5, "wr_addr");
        chk("wr_addr_miso", 32'(MISO), 32'd0);
        tick();
        chk("wr_addr_rv_once", 32'(rx_valid), 32'd0);
        chk("wr_addr_hold", 32'(rx_data), 32'h0A5);
        idle(2);

        // Read address then read data with 1-cycle memory response
        frame(10'h203, "rd_addr");
        chk("rd_addr_flag", 32'(dut.rd_addr_seen), 32'd1);
        idle(1);
        frame(10'h3AB, "rd_data");
        chk("rd_data_flag", 32'(dut.rd_addr_seen), 32'd0);
        tx_valid = 1'b1;
        tx_data  = 8'h3C;
        tick();
        tx_data  = 8'hFF;
        exp_byte = 8'h3C;
        for (int j = 7; j >= 0; j--) begin
            chk("rd_data_miso", 32'(MISO), 32'(exp_byte[j]));
            tick();
        end
        chk("rd_data_miso_end", 32'(MISO), 32'd0);
        tick();
        chk("rd_data_miso_ign", 32'(MISO), 32'd0);
        tx_valid = 1'b0;
        idle(1);

        // Read data with no pending address takes the READ_ADD path
        frame(10'h300, "rd_noaddr");
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        tick();
        chk("rd_noaddr_miso1", 32'(MISO), 32'd0);
        tick();
        chk("rd_noaddr_miso2", 32'(MISO), 32'd0);
        chk("rd_noaddr_flag", 32'(dut.rd_addr_seen), 32'd1);
        tx_valid = 1'b0;
        idle(1);

        // Abort after 6 bits of a write frame
        w    = 10'h0FF;
        SS_n = 1'b0;
        tick();
        for (int i = 9; i >= 4; i--) begin
            MOSI = w[i];
            tick();
        end
        SS_n = 1'b1;
        tick();
        chk("abort_rv1", 32'(rx_valid), 32'd0);
        tick();
        chk("abort_rv2", 32'(rx_valid), 32'd0);
        chk("abort_hold", 32'(rx_data), 32'h300);
        frame(10'h1F0, "post_abort");
        idle(1);

        // SS_n rises on the edge of the 10th bit
        w    = 10'h0CC;
        SS_n = 1'b0;
        tick();
        for (int i = 9; i >= 1; i--) begin
            MOSI = w[i];
            tick();
        end
        MOSI = w[0];
        SS_n = 1'b1;
        tick();
        chk("late_ss_rv", 32'(rx_valid), 32'd0);
        chk("late_ss_hold", 32'(rx_data), 32'h1F0);
        chk("abort_flag", 32'(dut.rd_addr_seen), 32'd1);
        idle(1);

        // Delayed memory response
        frame(10'h3C3, "delay");
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("delay_wait_miso", 32'(MISO), 32'd0);
        end
        tx_valid = 1'b1;
        tx_data  = 8'h81;
        tick();
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        exp_byte = 8'h81;
        for (int j = 7; j >= 0; j--) begin
            chk("delay_miso", 32'(MISO), 32'(exp_byte[j]));
            tick();
        end
        chk("delay_miso_end", 32'(MISO), 32'd0);
        idle(1);

        // Reset during bit 5 of a read-data frame
        frame(10'h211, "pre_rst");
        idle(1);
        w    = 10'h3F0;
        SS_n = 1'b0;
        tick();
        for (int i = 9; i >= 6; i--) begin
            MOSI = w[i];
            tick();
        end
        MOSI  = w[5];
        rst_n = 1'b0;
        tick();
        chk("mid_rst_rv", 32'(rx_valid), 32'd0);
        chk("mid_rst_miso", 32'(MISO), 32'd0);
        chk("mid_rst_data", 32'(rx_data), 32'd0);
        chk("mid_rst_state", 32'(dut.state), 32'd0);
        chk("mid_rst_flag", 32'(dut.rd_addr_seen), 32'd0);
        rst_n = 1'b1;
        for (int i = 4; i >= 0; i--) begin
            MOSI = w[i];
            tick();
            chk("post_rst_rv", 32'(rx_valid), 32'd0);
        end
        idle(2);
        chk("end_rv", 32'(rx_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
